// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Largest value representable in the given number of decimal digits.
  function automatic logic [31:0] bcd_max(input int digits);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < digits; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle between the GPIO word source and the BCD converter.
interface bin2bcd_if
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
);
  logic [BIN_W-1:0]        bin;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [NIB_W*DIGITS-1:0] bcd;
  logic                    ovf;

  modport master (output bin, start, input busy, done, bcd, ovf);
  modport slave  (input bin, start, output busy, done, bcd, ovf);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more.
// Purely combinational, zero latency, no flow control.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [NIB_W-1:0] in,
  output logic [NIB_W-1:0] out
);
  assign out = (in >= NIB_W'(5)) ? in + NIB_W'(3) : in;
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter; BIN_W+1 cycles from accepted start to done.
// Requests outside IDLE are dropped. Optional BIN2BCD_AUTO_EN retriggers on operand change.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
)(
  input  logic      clk,
  input  logic      reset,
  bin2bcd_if.slave  io
);
  localparam int          BCD_W  = NIB_W * DIGITS;
  localparam int          WORK_W = BCD_W + BIN_W;
  localparam int          CNT_W  = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX    = bcd_max(DIGITS);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] SHIFT = ST_SHIFT;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]        state;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] work_adj;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_pend;
  logic [31:0]       bin_ext;
  logic              over;
  logic [BIN_W-1:0]  sat;
  logic              req;

  // Clamp so the BCD field can always hold the result; ovf records the clamp.
  assign bin_ext = 32'(io.bin);
  assign over    = bin_ext > MAX;
  assign sat     = over ? MAX[BIN_W-1:0] : io.bin;

  assign work_adj[BIN_W-1:0] = work[BIN_W-1:0];
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .in  (work[BIN_W + NIB_W*d +: NIB_W]),
      .out (work_adj[BIN_W + NIB_W*d +: NIB_W])
    );
  end

`ifdef BIN2BCD_AUTO_EN
  logic [BIN_W-1:0] last_bin;
  logic             primed;

  assign req = io.start | ~primed | (io.bin != last_bin);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_bin <= '0;
      primed   <= 1'b0;
    end else if (state == IDLE && req) begin
      last_bin <= io.bin;
      primed   <= 1'b1;
    end
  end
`else
  assign req = io.start;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      io.busy  <= 1'b0;
      io.done  <= 1'b0;
      io.bcd   <= '0;
      io.ovf   <= 1'b0;
    end else begin
      io.done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            work     <= {{BCD_W{1'b0}}, sat};
            cnt      <= CNT_W'(BIN_W);
            ovf_pend <= over;
            io.busy  <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          work <= work_adj << 1;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          io.bcd  <= work[WORK_W-1 -: BCD_W];
          io.ovf  <= ovf_pend;
          io.done <= 1'b1;
          io.busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomized checks of bin2bcd_seq against an arithmetic decimal model.
module tb_bin2bcd_seq;
  localparam int BIN_W  = 16;
  localparam int DIGITS = 4;
  localparam int LAT    = BIN_W + 1;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bin2bcd_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) io ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  function automatic logic [4*DIGITS-1:0] ref_bcd(input longint unsigned v);
    longint unsigned s, m;
    logic [4*DIGITS-1:0] r;
    m = 10 ** DIGITS - 1;
    s = (v > m) ? m : v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v);
    return v > (10 ** DIGITS - 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

`ifndef BIN2BCD_AUTO_EN
  task automatic convert(input logic [BIN_W-1:0] v, input bit glitch);
    int lat, busy_n, extra;
    bit stable;
    logic [4*DIGITS-1:0] old;
    old = io.bcd; stable = 1'b1; lat = 0; busy_n = 0; extra = 0;
    @(negedge clk); io.bin = v; io.start = 1'b1;
    @(posedge clk); #1; io.start = 1'b0;
    if (io.busy) busy_n++;
    while (!io.done && lat < 40) begin
      if (glitch && lat == 4) begin io.bin = 16'd5678; io.start = 1'b1; end
      else if (glitch && lat == 16) io.start = 1'b1;
      else io.start = 1'b0;
      @(posedge clk); #1; lat++;
      if (io.busy) busy_n++;
      if (!io.done && io.bcd !== old) stable = 1'b0;
    end
    io.start = 1'b0;
    chk("latency", 64'(lat), 64'(LAT));
    chk("busy_cycles", 64'(busy_n), 64'(LAT));
    chk("bcd_held_until_done", 64'(stable), 64'd1);
    chk("bcd", 64'(io.bcd), 64'(ref_bcd(v)));
    chk("ovf", 64'(io.ovf), 64'(ref_ovf(v)));
    @(posedge clk); #1;
    chk("done_single_pulse", 64'(io.done), 64'd0);
    if (glitch) begin
      repeat (20) begin
        @(posedge clk); #1;
        if (io.done || io.busy) extra++;
      end
      chk("ignored_starts", 64'(extra), 64'd0);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    bit hit;
    logic [BIN_W-1:0] v, prev;
    reset = 1'b0; io.bin = '0; io.start = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 64'(io.busy), 64'd0);
    chk("rst_done", 64'(io.done), 64'd0);
    chk("rst_bcd",  64'(io.bcd),  64'd0);
    chk("rst_ovf",  64'(io.ovf),  64'd0);

`ifndef BIN2BCD_AUTO_EN
    @(negedge clk); reset = 1'b1;
    convert(16'd1234, 1'b0);
    convert(16'd0, 1'b0);
    convert(16'd9999, 1'b0);
    convert(16'd10000, 1'b0);
    convert(16'd65535, 1'b0);
    convert(16'd42, 1'b0);
    convert(16'd1234, 1'b1);
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 1) ? BIN_W'($urandom_range(0, 9999)) : BIN_W'($urandom_range(0, 65535));
      convert(v, 1'b0);
    end
    convert(16'd65535, 1'b0);

    // Abort a conversion in flight with reset.
    @(negedge clk); io.bin = 16'd4321; io.start = 1'b1;
    @(posedge clk); #1; io.start = 1'b0;
    repeat (7) @(posedge clk);
    #2; reset = 1'b0; #1;
    chk("abort_busy", 64'(io.busy), 64'd0);
    chk("abort_done", 64'(io.done), 64'd0);
    chk("abort_bcd",  64'(io.bcd),  64'd0);
    chk("abort_ovf",  64'(io.ovf),  64'd0);
    cnt = 0;
    repeat (3) begin @(posedge clk); #1; if (io.done) cnt++; end
    @(negedge clk); reset = 1'b1;
    repeat (25) begin @(posedge clk); #1; if (io.done || io.busy) cnt++; end
    chk("abort_no_done", 64'(cnt), 64'd0);
    convert(16'd77, 1'b0);
`else
    @(negedge clk); reset = 1'b1;
    cnt = 0;
    repeat (60) begin @(posedge clk); #1; if (io.done) cnt++; end
    chk("auto_first_count", 64'(cnt), 64'd1);
    chk("auto_first_bcd", 64'(io.bcd), 64'd0);
    chk("auto_first_ovf", 64'(io.ovf), 64'd0);
    prev = '0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) v = 16'h00FF;
      else begin
        v = BIN_W'($urandom_range(0, 65535));
        if (v == prev) v = v + 1'b1;
      end
      @(negedge clk); io.bin = v;
      hit = 1'b0;
      for (int c = 0; c < LAT + 1 && !hit; c++) begin
        @(posedge clk); #1;
        if (io.done) hit = 1'b1;
      end
      chk("auto_done_in_time", 64'(hit), 64'd1);
      chk("auto_bcd", 64'(io.bcd), 64'(ref_bcd(v)));
      chk("auto_ovf", 64'(io.ovf), 64'(ref_ovf(v)));
      cnt = 0;
      repeat (40) begin @(posedge clk); #1; if (io.done) cnt++; end
      chk("auto_hold_no_done", 64'(cnt), 64'd0);
      prev = v;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display driver on the Basys3 board. It takes the binary GPIO output word, converts it by iterative shift-and-add-3 (double dabble), and presents a registered, stable set of packed BCD digits that the display scanner can render as decimal. It runs in the 8 MHz system clock domain.

## Interface
- `BIN_W`, 16: binary input width; legal range 4..32.
- `DIGITS`, 4: number of BCD output digits; legal range 1..8.
- `clk` in 1: system clock (8 MHz PLL output).
- `reset` in 1: asynchronous, active-low reset. This block has one clock.
- `bin` in BIN_W: binary operand; sampled only when a conversion is accepted.
- `start` in 1: conversion request; accepted only in IDLE.
- `busy` out 1: high from acceptance until `done`.
- `done` out 1: single-cycle pulse; `bcd` and `ovf` are updated in the same cycle.
- `bcd` out 4*DIGITS: packed BCD result, digit 0 in bits [3:0]; held between conversions.
- `ovf` out 1: the last accepted operand exceeded 10^DIGITS−1.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: when `start`=1 (or an auto trigger fires), the block does the following:
  - Captures `bin`.
  - Computes `sat = (bin > MAX) ? MAX : bin`, with MAX = 10^DIGITS−1.
  - Loads the work register {4*DIGITS zeros, sat} and a shift counter of BIN_W.
  - Latches the pending ovf flag, then goes to SHIFT.
- SHIFT: each cycle, first add 3 to every BCD nibble ≥5, then shift the whole work register left 1. Decrement the counter. After BIN_W shifts, go to DONE.
- DONE: register the BCD field into `bcd`, pending flag into `ovf`, pulse `done`, go to IDLE.
- Work register width is 4*DIGITS+BIN_W. The add-3 never carries across nibbles, because a nibble ≥5 plus 3 is at most 12.
- `start` while `busy`, or in the DONE cycle, is ignored. No queueing.
- `bin` changes after capture have no effect on the conversion in flight.
- `bcd`/`ovf` change only in the DONE cycle. The display never sees a partial result.
- Reset values: `bcd`=0, `ovf`=0, `done`=0, `busy`=0, state IDLE, work register 0.
- Reset asserted mid-conversion aborts it immediately, with no `done` pulse.

## Timing
- `start` sampled high at edge k means:
  - `busy`=1 after edge k.
  - SHIFT occupies edges k+1..k+BIN_W.
  - DONE is active after edge k+BIN_W; the result is registered at edge k+BIN_W+1.
  - `done`=1 and the new `bcd` appear after edge k+BIN_W+1; `busy`=0 at that same edge.
- Total latency is BIN_W+1 cycles from the acceptance edge: 17 cycles at the defaults.
- Minimum spacing between conversions is BIN_W+2 cycles, because a new start is next accepted in the cycle after `done`.
- All outputs are registered. There is no combinational path from `start`/`bin` to any output.

## Configuration
- `BIN2BCD_AUTO_EN` defined: the block holds `last_bin` (the raw operand of the last accepted conversion) and a `primed` flag that clears on reset.
  - In IDLE, an auto trigger fires when `primed`=0 or `bin != last_bin`. It behaves exactly like `start`.
  - `start` still works; the two requests are ORed.
  - The Basys3 top builds with this macro, so the display follows `gpo` with no software action.
- Not defined: conversions occur only on `start`. `last_bin`/`primed` logic is absent.

## Structure
- `bin2bcd_pkg` holds:
  - the state enum (IDLE/SHIFT/DONE);
  - a constant function `bcd_max(DIGITS)` returning 10^DIGITS−1;
  - the nibble width constant (4).
- Sub-module `bcd_digit_adj` is combinational, one instance per digit via generate. It computes `out = (in >= 5) ? in + 3 : in`.
- The FSM, counter, saturation, and output registers live in the top `bin2bcd_seq`.

## Test plan
- `bin`=16'd1234, pulse `start` → after 17 cycles, `done`=1 for one cycle, `bcd`=16'h1234, `ovf`=0, `busy` high for exactly 17 cycles.
- `bin`=0, then 9999 → `bcd`=16'h0000, then 16'h9999, `ovf`=0 both times.
- `bin`=10000 and `bin`=65535 → `bcd`=16'h9999, `ovf`=1. A following conversion of 42 gives `bcd`=16'h0042, `ovf`=0.
- Start 1234, then pulse `start` with `bin`=5678 at cycle 5 and again in the DONE cycle → exactly one `done`, `bcd`=16'h1234.
- Start 4321, drive `reset`=0 at cycle 8 → outputs all 0, no `done`. Release reset, convert 77 → `bcd`=16'h0077.
- With `BIN2BCD_AUTO_EN`:
  - After reset with `bin`=0 → one conversion, `bcd`=0.
  - Holding `bin` constant → no further `done`.
  - Changing `bin` to 0x00FF → `bcd`=16'h0255 within 18 cycles.
